// File: rtl/nibble_add_seq.sv
// Multi-cycle wide adder: one shared 4-bit adder slice processes one nibble per
// clock, LSB first, between valid/ready handshakes on operand and result sides.

module parallel_adder_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IDXW-1:0]  idx_r;
    logic             carry_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [WIDTH-1:0] a_sh_s;
    logic [WIDTH-1:0] b_sh_s;
    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [3:0]       slice_sum_s;
    logic             slice_cout_s;

    // Two's-complement overflow from the operand and result sign bits.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Select the active operand nibbles by shifting the current index down to bit 0.
    always_comb begin
        a_sh_s  = a_r >> {idx_r, 2'b00};
        b_sh_s  = b_r >> {idx_r, 2'b00};
        a_nib_s = a_sh_s[3:0];
        b_nib_s = b_sh_s[3:0];
    end

    parallel_adder_4 u_slice (
        .a    (a_nib_s),
        .b    (b_nib_s),
        .cin  (carry_r),
        .sum  (slice_sum_s),
        .cout (slice_cout_s)
    );

    // Control FSM plus operand, carry and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            idx_r       <= {IDXW{1'b0}};
            carry_r     <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        idx_r   <= {IDXW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx_r == IDXW'(i)) begin
                            sum_r[4*i +: 4] <= slice_sum_s;
                        end
                    end
                    carry_r <= slice_cout_s;
                    // The index parks on the last nibble rather than wrapping.
                    if (idx_r == IDX_LAST) begin
                        cout_r      <= slice_cout_s;
                        ovf_r       <= signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1], slice_sum_s[3]);
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        idx_r <= idx_r + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign busy      = busy_r;

endmodule
